// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Provides the operand width, the requester count, the ALU control codes,
// the arbiter FSM state enum and the packed operation payload type.
package alu_arbiter_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned CTL_W   = 4;
    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    localparam logic [CTL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CTL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CTL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [CTL_W-1:0] ALU_BLT = 4'b0111;
    localparam logic [CTL_W-1:0] ALU_BGE = 4'b1000;
    localparam logic [CTL_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [CTL_W-1:0] ALU_SLL = 4'b1001;
    localparam logic [CTL_W-1:0] ALU_SRL = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [CTL_W-1:0]  ctl;
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
    } alu_op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU shared by all requesters.
// Ports:
//   i_op      operation payload {ctl, in1, in2}
//   o_out_c   result (0 for an illegal control code)
//   o_zero_c  result equals zero
//   o_err_c   control code is not one of the legal codes
// blt/bge compare the operands as signed values and return 1 or 0;
// shifts use the low SHAMT_W bits of in2 as the shift amount.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  alu_op_t            i_op,
    output logic [DATA_W-1:0]  o_out_c,
    output logic               o_zero_c,
    output logic               o_err_c
);

    logic [SHAMT_W-1:0] w_shamt;

    assign w_shamt = i_op.in2[SHAMT_W-1:0];

    // operation decode
    always_comb begin
        o_out_c = '0;
        o_err_c = 1'b0;
        case (i_op.ctl)
            ALU_AND: o_out_c = i_op.in1 & i_op.in2;
            ALU_OR:  o_out_c = i_op.in1 | i_op.in2;
            ALU_ADD: o_out_c = i_op.in1 + i_op.in2;
            ALU_SUB: o_out_c = i_op.in1 - i_op.in2;
            ALU_BLT: o_out_c = DATA_W'($signed(i_op.in1) <  $signed(i_op.in2));
            ALU_BGE: o_out_c = DATA_W'($signed(i_op.in1) >= $signed(i_op.in2));
            ALU_NOR: o_out_c = ~(i_op.in1 | i_op.in2);
            ALU_SLL: o_out_c = i_op.in1 << w_shamt;
            ALU_SRL: o_out_c = i_op.in1 >> w_shamt;
            default: o_err_c = 1'b1;
        endcase
    end

    assign o_zero_c = (o_out_c == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting two requesters access to one shared ALU.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester request valid
//   req_ready    per-requester accept (combinational, IDLE only, one-hot)
//   req_ctl      {r1, r0} 4-bit control codes
//   req_in1/2    {r1, r0} 32-bit operands
//   rsp_valid    one-hot response valid to the owning requester
//   rsp_ready    per-requester response accept
//   rsp_out      registered result; rsp_zero / rsp_err its flags
//   busy         high whenever an operation is in flight
// Flow: IDLE (grant + latch) -> EXEC (ALU result registered) -> RESP (hold
// until owner accepts) -> IDLE.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = alu_arbiter_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*CTL_W-1:0]    req_ctl,
    input  logic [NREQ*DATA_W-1:0]   req_in1,
    input  logic [NREQ*DATA_W-1:0]   req_in2,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]        rsp_out,
    output logic                     rsp_zero,
    output logic                     rsp_err,
    output logic                     busy
);

    state_e              r_state;
    state_e              w_next_state;
    logic                r_last_grant;
    logic                r_owner;
    logic                w_winner;
    logic                w_grant;
    logic [NREQ-1:0]     w_req_ready;
    alu_op_t             r_op;
    alu_op_t             w_req_op;
    logic [NREQ-1:0]     r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_out;
    logic                r_rsp_zero;
    logic                r_rsp_err;
    logic                r_busy;
    logic [DATA_W-1:0]   w_alu_out;
    logic                w_alu_zero;
    logic                w_alu_err;

    // payload of the requester currently selected by the arbiter
    always_comb begin
        w_req_op.ctl = w_winner ? req_ctl[2*CTL_W-1:CTL_W]    : req_ctl[CTL_W-1:0];
        w_req_op.in1 = w_winner ? req_in1[2*DATA_W-1:DATA_W]  : req_in1[DATA_W-1:0];
        w_req_op.in2 = w_winner ? req_in2[2*DATA_W-1:DATA_W]  : req_in2[DATA_W-1:0];
    end

    // next state, round-robin winner and grant
    always_comb begin
        w_next_state = r_state;
        w_winner     = 1'b0;
        w_grant      = 1'b0;
        w_req_ready  = '0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid == 2'b11) begin
                    w_winner = ~r_last_grant;
                end else begin
                    w_winner = req_valid[1];
                end
                if (|req_valid) begin
                    w_grant      = 1'b1;
                    w_req_ready  = NREQ'(1) << w_winner;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: begin
                if (rsp_ready[r_owner]) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ready is forced low during reset so no requester sees a discarded handshake
    assign req_ready = w_req_ready & {NREQ{rst_n}};

    alu_arbiter_alu u_alu (
        .i_op     (r_op),
        .o_out_c  (w_alu_out),
        .o_zero_c (w_alu_zero),
        .o_err_c  (w_alu_err)
    );

    // all state: FSM, arbitration history, latched operation, response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op         <= '0;
            r_rsp_valid  <= '0;
            r_rsp_out    <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != ST_IDLE);
            if (w_grant) begin
                r_last_grant <= w_winner;
                r_owner      <= w_winner;
                r_op         <= w_req_op;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_out   <= w_alu_out;
                r_rsp_zero  <= w_alu_zero;
                r_rsp_err   <= w_alu_err;
                r_rsp_valid <= NREQ'(1) << r_owner;
            end
            if ((r_state == ST_RESP) && rsp_ready[r_owner]) begin
                r_rsp_valid <= '0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_out   = r_rsp_out;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// transaction-level reference model.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_ctl;
    logic [63:0] req_in1;
    logic [63:0] req_in2;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_out;
    logic        rsp_zero;
    logic        rsp_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_resp  = 0;

    // reference model: one in-flight transaction, age counted from its grant
    bit          m_inflight;
    int          m_age;
    int          m_owner;
    int          m_last;
    logic [3:0]  m_ctl;
    logic [31:0] m_a, m_b, m_out;
    logic        m_zero, m_err;
    logic [1:0]  seen_ready;

    logic [3:0] legal_codes [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                    4'b0111, 4'b1000, 4'b1100, 4'b1001, 4'b1010};

    alu_arbiter #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ctl   (req_ctl),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
        end
    endtask

    // returns {err, zero, out}
    function automatic logic [33:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic        e;
        int          sh;
        r  = 32'd0;
        e  = 1'b0;
        sh = int'(b % 32);
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            4'b1001: r = a << sh;
            4'b1010: r = a >> sh;
            default: e = 1'b1;
        endcase
        return {e, (r == 32'd0), r};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return 32'($urandom());
        endcase
    endfunction

    // per-cycle comparison against the model, then model advance for the next edge
    task automatic model_check();
        logic [1:0]  exp_ready;
        logic [1:0]  exp_vld;
        logic [33:0] res;
        int          w;
        if (!rst_n) begin
            m_inflight = 1'b0;
            m_age      = 0;
            m_last     = 1;
            m_out      = 32'd0;
            m_zero     = 1'b0;
            m_err      = 1'b0;
            chk("reset_ctrl", 64'({req_ready, rsp_valid, busy}), 64'd0);
            chk("reset_data", 64'({rsp_err, rsp_zero, rsp_out}), 64'd0);
            seen_ready = req_ready;
            return;
        end
        exp_ready = 2'b00;
        w = -1;
        if (!m_inflight && (req_valid != 2'b00)) begin
            if (req_valid == 2'b11) w = 1 - m_last;
            else                    w = req_valid[1] ? 1 : 0;
            exp_ready[w] = 1'b1;
        end
        exp_vld = 2'b00;
        if (m_inflight && (m_age >= 2)) exp_vld[m_owner] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
        chk("busy", 64'(busy), 64'(m_inflight));
        chk("rsp_data", 64'({rsp_err, rsp_zero, rsp_out}), 64'({m_err, m_zero, m_out}));
        seen_ready = req_ready;
        if (m_inflight) begin
            if (m_age >= 2) begin
                if (rsp_ready[m_owner]) begin
                    m_inflight = 1'b0;
                    n_resp++;
                end
            end else begin
                m_age  = 2;
                res    = ref_alu(m_ctl, m_a, m_b);
                m_out  = res[31:0];
                m_zero = res[32];
                m_err  = res[33];
            end
        end else if (w >= 0) begin
            m_inflight = 1'b1;
            m_age      = 1;
            m_owner    = w;
            m_last     = w;
            m_ctl      = (w == 1) ? req_ctl[7:4]   : req_ctl[3:0];
            m_a        = (w == 1) ? req_in1[63:32] : req_in1[31:0];
            m_b        = (w == 1) ? req_in2[63:32] : req_in2[31:0];
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_payload(input int i, input logic [3:0] c, input logic [31:0] a,
                               input logic [31:0] b);
        if (i == 0) begin
            req_ctl[3:0]   = c;
            req_in1[31:0]  = a;
            req_in2[31:0]  = b;
        end else begin
            req_ctl[7:4]   = c;
            req_in1[63:32] = a;
            req_in2[63:32] = b;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        sample();
        advance();
        rst_n = 1'b1;
    endtask

    // issue one operation from requester i and wait for its response
    task automatic run_op(input int i, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] o, output logic [1:0] v,
                          output logic z, output logic e, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        o = 32'd0; v = 2'b00; z = 1'b0; e = 1'b0;
        set_payload(i, c, a, b);
        req_valid[i] = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            sample();
            got = req_ready[i];
            advance();
        end
        req_valid[i] = 1'b0;
        chk("grant_seen", 64'(got), 64'd1);
        got = 1'b0;
        for (int k = 1; k <= 10 && !got; k++) begin
            sample();
            if (rsp_valid != 2'b00) begin
                got = 1'b1;
                lat = k;
                o = rsp_out; v = rsp_valid; z = rsp_zero; e = rsp_err;
            end
            advance();
        end
        chk("rsp_seen", 64'(got), 64'd1);
    endtask

    initial begin
        logic [31:0] o;
        logic [1:0]  v;
        logic        z, e;
        logic [1:0]  pend;
        int          lat;

        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_ctl    = 8'h22;
        req_in1    = 64'd1;
        req_in2    = 64'd1;
        rsp_ready  = 2'b11;
        seen_ready = 2'b00;
        m_inflight = 1'b0;
        m_age      = 0;
        m_owner    = 0;
        m_last     = 1;
        m_ctl      = 4'd0;
        m_a        = 32'd0;
        m_b        = 32'd0;
        m_out      = 32'd0;
        m_zero     = 1'b0;
        m_err      = 1'b0;
        #1;
        chk("rst_async_ready", 64'(req_ready), 64'd0);
        sample(); advance();
        sample(); advance();
        rst_n     = 1'b1;
        req_valid = 2'b00;

        // single requester add, latency 2
        run_op(0, 4'b0010, 32'd5, 32'd7, o, v, z, e, lat);
        chk("add_out", 64'(o), 64'd12);
        chk("add_owner", 64'(v), 64'b01);
        chk("add_flags", 64'({z, e}), 64'd0);
        chk("add_latency", 64'(lat), 64'd2);

        // tie after reset: r0 first, then r1, then r0 again
        do_reset();
        req_valid = 2'b11;
        set_payload(0, 4'b0110, 32'd9, 32'd9);
        set_payload(1, 4'b0000, 32'h0000_00F0, 32'h0000_000F);
        sample(); chk("tie1_grant", 64'(req_ready), 64'b01); advance();
        req_valid = 2'b10;
        sample(); chk("tie_exec_noready", 64'(req_ready), 64'b00); advance();
        sample();
        chk("tie_rsp1", 64'({rsp_valid, rsp_out, rsp_zero}), 64'({2'b01, 32'd0, 1'b1}));
        advance();
        sample(); chk("tie2_grant", 64'(req_ready), 64'b10); advance();
        req_valid = 2'b00;
        sample(); advance();
        sample();
        chk("tie_rsp2", 64'({rsp_valid, rsp_out, rsp_zero}), 64'({2'b10, 32'd0, 1'b1}));
        advance();
        req_valid = 2'b11;
        sample(); chk("tie3_grant", 64'(req_ready), 64'b01); advance();
        req_valid = 2'b00;
        repeat (4) begin sample(); advance(); end

        // back-pressure: owner r1 stalls, non-owner rsp_ready ignored
        req_valid = 2'b10;
        set_payload(1, 4'b0001, 32'h1234_0000, 32'h0000_5678);
        sample(); chk("bp_grant", 64'(req_ready), 64'b10); advance();
        req_valid = 2'b11;
        set_payload(0, 4'b0010, 32'd1, 32'd2);
        rsp_ready = 2'b01;
        sample(); advance();
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("bp_hold", 64'({rsp_valid, req_ready, busy, rsp_out}),
                64'({2'b10, 2'b00, 1'b1, 32'h1234_5678}));
            advance();
        end
        rsp_ready = 2'b11;
        sample(); chk("bp_handshake_noready", 64'(req_ready), 64'b00); advance();
        sample(); chk("bp_next_grant", 64'(req_ready), 64'b01); advance();
        req_valid = 2'b00;
        repeat (4) begin sample(); advance(); end

        // illegal control code
        run_op(1, 4'b1111, 32'hDEAD, 32'hBEEF, o, v, z, e, lat);
        chk("illegal_out", 64'({v, o}), 64'({2'b10, 32'd0}));
        chk("illegal_flags", 64'({z, e}), 64'b11);

        // add wraps modulo 2^32
        run_op(0, 4'b0010, 32'hFFFF_FFFF, 32'd1, o, v, z, e, lat);
        chk("ovf_out", 64'(o), 64'd0);
        chk("ovf_flags", 64'({z, e}), 64'b10);

        // reset during EXEC discards the operation
        run_op(0, 4'b0010, 32'd5, 32'd7, o, v, z, e, lat);
        chk("pre_rst_out", 64'(o), 64'd12);
        req_valid = 2'b01;
        set_payload(0, 4'b0110, 32'd20, 32'd3);
        sample(); chk("rst_op_grant", 64'(req_ready), 64'b01); advance();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs",
            64'({rsp_out, rsp_zero, rsp_err, rsp_valid, busy, req_ready}), 64'd0);
        sample(); advance();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sample(); chk("no_ghost_rsp", 64'(rsp_valid), 64'd0); advance();
        end

        // randomized traffic; requesters hold payload until accepted
        pend = 2'b00;
        n_resp = 0;
        repeat (4000) begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && seen_ready[i]) pend[i] = 1'b0;
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    pend[i] = 1'b1;
                    if ($urandom_range(0, 9) == 0)
                        set_payload(i, 4'($urandom_range(0, 15)), pick_operand(), pick_operand());
                    else
                        set_payload(i, legal_codes[$urandom_range(0, 8)], pick_operand(),
                                    pick_operand());
                end
            end
            req_valid    = pend;
            rsp_ready[0] = ($urandom_range(0, 3) != 0);
            rsp_ready[1] = ($urandom_range(0, 3) != 0);
            sample();
            advance();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (6) begin sample(); advance(); end
        chk("rnd_progress", 64'(n_resp > 200), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
